// File: rtl/inst_fetch_queue_pkg.sv
// Shared instruction/CPU header definitions used by the fetch queue.
// Holds the default queue depth, the NOP word and the stored entry layout.
package inst_fetch_queue_pkg;

    localparam int IFQ_DEPTH = 4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ifqEntry_t;

    // Occupancy-derived view of the queue; there is no separate state register.
    typedef enum logic [1:0] {
        IFQ_EMPTY,
        IFQ_PARTIAL,
        IFQ_FULL
    } ifqState_e;

    localparam ifqEntry_t NOP_ENTRY = '{pc: 32'h0000_0000, instr: NOP_WORD, adel: 1'b0};

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue between fetch and decode: a small circular flop-array FIFO
// with no bypass, flush-to-empty on redirects, and NOP outputs when empty.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    input  logic                     in_adel,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic                     out_adel,
    input  logic                     stallD,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    ifqEntry_t        storage [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] occupancy;
    ifqState_e        queueState;
    ifqEntry_t        headEntry;
    logic             doPush;
    logic             doPop;

    always_comb begin
        queueState = IFQ_PARTIAL;
        if (occupancy == '0) begin
            queueState = IFQ_EMPTY;
        end else if (occupancy == FULL_COUNT) begin
            queueState = IFQ_FULL;
        end
    end

    // in_ready looks only at occupancy, so a full queue refuses a push even when it pops.
    assign in_ready  = (queueState != IFQ_FULL);
    assign out_valid = (queueState != IFQ_EMPTY);

    assign doPush = in_valid && in_ready && !flush;
    assign doPop  = out_valid && !stallD && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({doPush, doPop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through occupancy.
    always_ff @(posedge clk) begin
        if (doPush) begin
            storage[wrPtr] <= '{pc: in_pc, instr: in_instr, adel: in_adel};
        end
    end

    assign headEntry = out_valid ? storage[rdPtr] : NOP_ENTRY;

    assign out_pc    = headEntry.pc;
    assign out_instr = headEntry.instr;
    assign out_adel  = headEntry.adel;
    assign count     = occupancy;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a queue-based reference model tracks expected
// contents at each clock edge, and a negedge monitor compares the DUT outputs against it.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } tbEntry;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_adel = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_adel;
    logic        stallD = 1'b1;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int nChecks = 0;
    int nFails  = 0;

    tbEntry expQ[$];

    inst_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_adel(in_adel),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_adel(out_adel),
        .stallD(stallD), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a FIFO of expected entries updated with the interface rules.
    always @(posedge clk) begin
        if (!resetn) begin
            expQ.delete();
        end else if (flush) begin
            expQ.delete();
        end else begin
            bit canPush;
            bit canPop;
            canPush = in_valid && (expQ.size() < DEPTH);
            canPop  = (expQ.size() > 0) && !stallD;
            if (canPop) void'(expQ.pop_front());
            if (canPush) expQ.push_back('{pc: in_pc, instr: in_instr, adel: in_adel});
        end
    end

    // Monitor: compares everything visible on the outputs once per cycle.
    always @(negedge clk) begin
        int sz;
        sz = expQ.size();
        checkOutput("count", 32'(count), 32'(sz));
        checkOutput("out_valid", 32'(out_valid), 32'(sz != 0));
        checkOutput("in_ready", 32'(in_ready), 32'(sz != DEPTH));
        if (sz != 0) begin
            checkOutput("head_pc", out_pc, expQ[0].pc);
            checkOutput("head_instr", out_instr, expQ[0].instr);
            checkOutput("head_adel", 32'(out_adel), 32'(expQ[0].adel));
        end else begin
            checkOutput("nop_pc", out_pc, 32'h0);
            checkOutput("nop_instr", out_instr, 32'h0);
            checkOutput("nop_adel", 32'(out_adel), 32'h0);
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic adel, input logic stall, input logic fl);
        @(negedge clk);
        in_valid = v;
        in_pc    = pc;
        in_instr = instr;
        in_adel  = adel;
        stallD   = stall;
        flush    = fl;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset hold and checks while reset is asserted
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_count", 32'(count), 32'h0);
        resetn = 1'b1;

        // Fill with decode stalled; head stays at the first PC
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 32'hBFC0_0000 + 32'(4 * i), $urandom, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("full_count", 32'(count), 32'd4);
        checkOutput("full_in_ready", 32'(in_ready), 32'h0);
        checkOutput("full_head_pc", out_pc, 32'hBFC0_0000);

        // Full queue: pop happens, push refused
        applyStimulus(1'b1, 32'hDEAD_0000, $urandom, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("refuse_count", 32'(count), 32'd3);
        checkOutput("refuse_head_pc", out_pc, 32'hBFC0_0004);

        // Drop to two entries, then sustained push+pop wraps the pointers
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++)
            applyStimulus(1'b1, 32'hBFC0_0010 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("steady_count", 32'(count), 32'd2);
        checkOutput("steady_head_pc", out_pc, 32'hBFC0_0024);

        // Flush with a concurrent push, then redirect target enters
        applyStimulus(1'b1, 32'hBFC0_1000, $urandom, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'hBFC0_2000, $urandom, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h8000_0180, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'h0);
        checkOutput("flush_out_instr", out_instr, 32'h0);
        applyStimulus(1'b1, 32'hBFC0_0001, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0);
        checkOutput("redirect_head_pc", out_pc, 32'h8000_0180);

        // Address-error entry passes through unmodified
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("adel_flag", 32'(out_adel), 32'h1);
        checkOutput("adel_pc", out_pc, 32'hBFC0_0001);
        applyStimulus(1'b1, 32'hBFC0_0100, $urandom, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_reset_count", 32'(count), 32'd2);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'h0);
        checkOutput("async_count", 32'(count), 32'h0);
        expQ.delete();
        @(negedge clk);
        resetn = 1'b1;

        // Randomized traffic with occasional flushes
        for (int i = 0; i < 500; i++)
            applyStimulus(($urandom_range(0, 9) < 7), $urandom, $urandom, 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-002 DEPTH parameter SHALL default to 4 and set the number of queue entries, power of two, minimum 2.
REQ-003 clk  input  1  the single rising-edge clock.
REQ-004 resetn  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  the fetch stage presents an instruction.
REQ-006 in_pc  input  32  the PC of the presented instruction.
REQ-007 in_instr  input  32  the instruction word.
REQ-008 in_adel  input  1  fetch address-error flag that travels with the instruction.
REQ-009 in_ready  output  1  the queue accepts a push this cycle.
REQ-010 out_valid  output  1  the head entry is valid for decode.
REQ-011 out_pc  output  32  the head PC.
REQ-012 out_instr  output  32  the head instruction, driven to the decode Op/func fields.
REQ-013 out_adel  output  1  the head address-error flag.
REQ-014 stallD  input  1  decode holds its current instruction, so no pop occurs.
REQ-015 flush  input  1  branch, jump, exception or ERET redirect that discards the queue.
REQ-016 count  output  log2(DEPTH)+1  occupancy, for debug and for the fetch throttle.

Function
REQ-017 Push SHALL occur iff in_valid && in_ready && !flush.
REQ-018 Pop SHALL occur iff out_valid && !stallD && !flush.
REQ-019 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on stallD, so there is no combinational path from stallD to in_ready.
REQ-020 When the queue is full, a push SHALL be refused even if a pop happens in the same cycle.
REQ-021 out_valid SHALL equal (count != 0); no bypass, so an entry pushed at edge N SHALL first appear on the outputs after edge N.
REQ-022 When out_valid=0, out_instr SHALL be 32'h0 (NOP), out_pc 32'h0 and out_adel 0.
REQ-023 When out_valid=1, out_pc, out_instr and out_adel SHALL be driven from the head entry.
REQ-024 Simultaneous push and pop on a non-full, non-empty queue SHALL leave count unchanged and advance both pointers.
REQ-025 A simultaneous push and pop on an empty queue cannot occur, because a pop requires out_valid.
REQ-026 Read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-027 count SHALL change by +1, -1 or 0 only, except on flush.
REQ-028 On flush, at the next edge count, wptr and rptr SHALL return to 0, the same-cycle push SHALL be dropped, and the same-cycle pop SHALL NOT occur.
REQ-029 Flush SHALL take priority over stallD, push and pop.
REQ-030 Entries SHALL be stored as {pc, instr, adel} without modification, including entries with adel=1.
REQ-031 The block SHALL have no other state machine; its states are EMPTY (count=0), PARTIAL and FULL (count=DEPTH), and they are derived from count.

Reset
REQ-032 While resetn=0, count, wptr and rptr SHALL be 0, out_valid 0 and in_ready 1, with outputs per REQ-022.
REQ-033 Storage array contents need not be reset.
REQ-034 Assertion of reset mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-035 The first push SHALL be possible on the first rising edge after deassertion.

Structure
REQ-036 IFQ_DEPTH default and the NOP word constant SHALL reside in the shared instruction/CPU header package.
REQ-037 The block SHALL be a single module; the storage SHALL be a flop array and SHALL NOT be a separate RAM sub-module.
REQ-038 All outputs SHALL be combinational from registered state only.

Verification
REQ-039 Reset then push PCs 0xBFC00000..0xBFC0000C with stallD=1 -> count=4, in_ready=0, and out_pc stays 0xBFC00000 throughout.
REQ-040 Full queue, stallD=0, in_valid=1 for one cycle -> the pop occurs, the push is refused, count=3, and out_pc advances to 0xBFC00004.
REQ-041 count=2, with push of 0xBFC00010 and pop in the same cycle -> count stays 2; after 6 continuous push+pop cycles the pointers have wrapped and the PC order is preserved.
REQ-042 count=3, flush=1 together with in_valid=1 -> after the edge count=0, out_valid=0 and out_instr=0; next-cycle push of 0x80000180 appears as head one cycle later.
REQ-043 Push entry with in_adel=1 and PC 0xBFC00001 -> it emerges with out_adel=1 and out_pc=0xBFC00001, unmodified.
REQ-044 resetn pulsed low mid-stream with count=2, asynchronous to clk -> out_valid=0 and count=0 before the next clock edge.
